// File: rtl/pe_group_acc.sv
// Multi-pass PE group: TAPS-wide signed dot product per beat, requantised and accumulated
// across beats until a last beat, then shifted and saturated/wrapped for writeback.
module pe_group_acc #(
    parameter int TAPS       = 5,
    parameter int DW         = 8,
    parameter int PROD_SHIFT = 7,
    parameter int OUT_SHIFT  = 2,
    parameter int OUT_W      = 10,
    parameter int ACC_W      = 24,
    parameter int MAX_BEATS  = 64,
    parameter int DONE_LEN   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [TAPS*DW-1:0]      ifmap,
    input  logic [TAPS*DW-1:0]      weight,
    input  logic                    sat_en,
    input  logic                    clear,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    wb_done,
    output logic                    busy,
    output logic                    err
);

    localparam int PW    = 2 * DW;
    localparam int SUM_W = PW + $clog2(TAPS);
    localparam int BC_W  = $clog2(MAX_BEATS + 1);
    localparam int DC_W  = $clog2(DONE_LEN + 1);

    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BEATS);
    localparam logic [DC_W-1:0] DC_LEN = DC_W'(DONE_LEN);
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] r);
        if (r > OUT_MAX)
            return OUT_MAX[OUT_W-1:0];
        else if (r < OUT_MIN)
            return OUT_MIN[OUT_W-1:0];
        else
            return r[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] wrap_out(input logic signed [ACC_W-1:0] r);
        return r[OUT_W-1:0];
    endfunction

    logic signed [PW-1:0]    prod_c  [TAPS];
    logic signed [PW-1:0]    prod_p1 [TAPS];
    logic                    vld_p1, last_p1;
    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] s_p2;
    logic                    vld_p2, last_p2;
    logic signed [ACC_W-1:0] acc_p3, acc_sum, r_c;
    logic [BC_W-1:0]         beat_cnt;
    logic                    pass_open;
    logic [DC_W-1:0]         done_cnt;

    always_comb begin
        for (int i = 0; i < TAPS; i++)
            prod_c[i] = PW'($signed(ifmap[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++)
            sum_c = sum_c + SUM_W'(prod_p1[i]);
    end

    assign acc_sum = acc_p3 + ACC_W'(s_p2);
    assign r_c     = acc_sum >>> OUT_SHIFT;

    // E0: per-tap products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            for (int i = 0; i < TAPS; i++)
                prod_p1[i] <= '0;
        end else begin
            vld_p1  <= in_valid & ~clear;
            last_p1 <= in_valid & in_last & ~clear;
            prod_p1 <= prod_c;
        end
    end

    // E1: tap reduction and per-beat requantisation (floor shift)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            s_p2    <= '0;
        end else begin
            vld_p2  <= vld_p1 & ~clear;
            last_p2 <= last_p1 & ~clear;
            s_p2    <= sum_c >>> PROD_SHIFT;
        end
    end

    // E2: accumulate, or close the pass and emit the result; out_data holds across clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_p3    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            acc_p3    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_p2 & last_p2;
            if (vld_p2) begin
                if (last_p2) begin
                    acc_p3   <= '0;
                    out_data <= sat_en ? sat_out(r_c) : wrap_out(r_c);
                end else begin
                    acc_p3 <= acc_sum;
                end
            end
        end
    end

    // Pass bookkeeping; a new pass's first beat wins over the old pass closing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            pass_open <= 1'b0;
            err       <= 1'b0;
            done_cnt  <= '0;
        end else if (clear) begin
            beat_cnt  <= '0;
            pass_open <= 1'b0;
            err       <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (in_valid) begin
                if (beat_cnt == BC_MAX)
                    err <= 1'b1;
                if (in_last)
                    beat_cnt <= '0;
                else if (beat_cnt != BC_MAX)
                    beat_cnt <= beat_cnt + 1'b1;
            end
            if (in_valid && !in_last)
                pass_open <= 1'b1;
            else if (vld_p2 && last_p2)
                pass_open <= 1'b0;
            if (out_valid)
                done_cnt <= DC_LEN;
            else if (done_cnt != '0)
                done_cnt <= done_cnt - 1'b1;
        end
    end

    assign wb_done = (done_cnt != '0);
    assign busy    = vld_p1 | vld_p2 | (beat_cnt != '0) | pass_open;

endmodule

// File: tb/tb_pe_group_acc.sv
// Directed bench for pe_group_acc: latency, accumulation, requantisation, saturation/wrap,
// clear, async reset, error flag and done-pulse merging.
module tb_pe_group_acc;

    localparam int TAPS = 5;
    localparam int DW   = 8;
    localparam int OW   = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_last = 1'b0;
    logic [TAPS*DW-1:0]     ifmap = '0;
    logic [TAPS*DW-1:0]     weight = '0;
    logic                   sat_en = 1'b1;
    logic                   clear = 1'b0;
    logic                   out_valid;
    logic signed [OW-1:0]   out_data;
    logic                   wb_done;
    logic                   busy;
    logic                   err;

    int errors = 0;
    int checks = 0;

    pe_group_acc #(
        .TAPS(TAPS), .DW(DW), .PROD_SHIFT(7), .OUT_SHIFT(2), .OUT_W(OW),
        .ACC_W(24), .MAX_BEATS(4), .DONE_LEN(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .ifmap(ifmap), .weight(weight), .sat_en(sat_en), .clear(clear),
        .out_valid(out_valid), .out_data(out_data), .wb_done(wb_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_all(input int a, input int b);
        for (int i = 0; i < TAPS; i++) begin
            ifmap[i*DW +: DW]  = a[7:0];
            weight[i*DW +: DW] = b[7:0];
        end
    endtask

    task automatic beat(input logic last);
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Issues nbeats back to back (last on the final one) and waits a bounded time for the result.
    task automatic run_pass(input int nbeats, output logic got, output int data);
        for (int b = 0; b < nbeats; b++) begin
            in_valid = 1'b1;
            in_last  = (b == nbeats - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        got  = 1'b0;
        data = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            if (out_valid) begin
                got  = 1'b1;
                data = out_data;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 10'sd0) begin errors++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL rst_wb_done got=%b exp=0", wb_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_single_beat();
        sat_en = 1'b1;
        set_all(64, 64);
        beat(1'b1);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 10'sd40) begin errors++; $display("FAIL single_data got=%0d exp=40", out_data); end
        checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL single_done_early got=%b exp=0", wb_done); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (wb_done !== (c <= 3) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_done_c%0d got done=%b valid=%b exp done=%b valid=0", c, wb_done, out_valid, (c <= 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(5);
        set_all(64, 64);
        beat(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_first got=%b exp=1", busy); end
        beat(1'b0);
        beat(1'b1);
        beat(1'b1);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_pre got valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 10'sd120) begin errors++; $display("FAIL b2b_three got valid=%b data=%0d exp valid=1 data=120", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 10'sd40) begin errors++; $display("FAIL b2b_single got valid=%b data=%0d exp valid=1 data=40", out_valid, out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        logic got;
        int   d;
        idle(5);
        set_all(127, 127);
        sat_en = 1'b1;
        run_pass(4, got, d);
        checks++; if (!got || d !== 511) begin errors++; $display("FAIL sat_clamp got valid=%b data=%0d exp 511", got, d); end
        // sat_en flips after the last beat enters but before the result is formed
        for (int b = 0; b < 4; b++) beat(b == 3);
        sat_en = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== -10'sd394) begin errors++; $display("FAIL sat_wrap got valid=%b data=%0d exp -394", out_valid, out_data); end
        sat_en = 1'b1;
        set_all(-128, -128);
        run_pass(1, got, d);
        checks++; if (!got || d !== 160) begin errors++; $display("FAIL neg_square got valid=%b data=%0d exp 160", got, d); end
    endtask

    task automatic test_floor();
        logic got;
        int   d;
        idle(5);
        set_all(0, 0);
        ifmap[7:0]  = 8'hFF;
        weight[7:0] = 8'h01;
        run_pass(1, got, d);
        checks++; if (!got || d !== -1) begin errors++; $display("FAIL floor_neg got valid=%b data=%0d exp -1", got, d); end
    endtask

    task automatic test_clear();
        logic got;
        int   d;
        idle(5);
        set_all(64, 64);
        beat(1'b0);
        beat(1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got=%b exp=0", busy); end
        run_pass(1, got, d);
        checks++; if (!got || d !== 40) begin errors++; $display("FAIL clear_fresh got valid=%b data=%0d exp 40", got, d); end
    endtask

    task automatic test_async_reset();
        logic got;
        int   d;
        idle(5);
        set_all(64, 64);
        run_pass(1, got, d);
        beat(1'b0);
        beat(1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'sd0 || wb_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got valid=%b data=%0d done=%b busy=%b err=%b exp all 0", out_valid, out_data, wb_done, busy, err);
        end
        #1;
        rst = 1'b1;
        tick();
        run_pass(1, got, d);
        checks++; if (!got || d !== 40) begin errors++; $display("FAIL post_rst got valid=%b data=%0d exp 40", got, d); end
    endtask

    task automatic test_err();
        logic got;
        int   d;
        idle(5);
        set_all(64, 64);
        for (int b = 0; b < 4; b++) beat(1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got=%b exp=0", err); end
        beat(1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        run_pass(1, got, d);
        checks++; if (!got || d !== 240) begin errors++; $display("FAIL err_pass got valid=%b data=%0d exp 240", got, d); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_done_merge();
        logic exp_ov, exp_dn;
        idle(6);
        set_all(64, 64);
        beat(1'b1);
        for (int c = 1; c <= 10; c++) begin
            in_valid = (c == 2 || c == 4);
            in_last  = in_valid;
            tick();
            exp_ov = (c == 2 || c == 4 || c == 6);
            exp_dn = (c >= 3 && c <= 9);
            checks++;
            if (out_valid !== exp_ov || wb_done !== exp_dn) begin
                errors++;
                $display("FAIL merge_c%0d got valid=%b done=%b exp valid=%b done=%b", c, out_valid, wb_done, exp_ov, exp_dn);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_saturation();
        test_floor();
        test_clear();
        test_async_reset();
        test_err();
        test_done_merge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_group_acc.md
# pe_group_acc

Parametrised multi-pass processing-element group for the CNN accelerator datapath. Each beat computes a TAPS-wide signed dot product of ifmap and weight vectors, requantises it by an arithmetic right shift, and accumulates it across beats (input channels) until a beat marked last. The closed pass is then shifted, saturated or wrapped to the output width, and handed to writeback with a valid strobe and a stretched done pulse. It replaces fixed 5-tap, single-pass groups in the conv array and sits between the weight/ifmap buffers and the writeback unit.

## Interface
- TAPS, 5: taps per beat, 1..16
- DW, 8: signed ifmap/weight width
- PROD_SHIFT, 7: arithmetic right shift applied to each beat sum
- OUT_SHIFT, 2: arithmetic right shift applied to the closed accumulator
- OUT_W, 10: signed output width
- ACC_W, 24: signed accumulator width
- MAX_BEATS, 64: beats allowed per pass before the error flag sets
- DONE_LEN, 3: done pulse length in cycles, at least 1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present on ifmap/weight
- in_last  in  1  beat closes the pass; qualified by in_valid
- ifmap  in  TAPS*DW  packed signed ifmap vector; tap i = bits [i*DW +: DW]
- weight  in  TAPS*DW  packed signed weight vector, same packing
- sat_en  in  1  1 = saturate output, 0 = wrap (keep low OUT_W bits)
- clear  in  1  synchronous flush of pipeline, accumulator and counters
- out_valid  out  1  one-cycle strobe, out_data valid
- out_data  out  OUT_W  signed pass result
- wb_done  out  1  done pulse to writeback
- busy  out  1  pass open or pipeline occupied
- err  out  1  sticky: beat count exceeded MAX_BEATS

## Operation
- Stage 1 (E0, beat sampled): prod[i] = ifmap[i]*weight[i], signed, 2*DW bits each, all registered; v1 <= in_valid; l1 <= in_valid & in_last.
- Stage 2 (E1): s = (sum of prod[i], sign-extended to 2*DW+clog2(TAPS)) >>> PROD_SHIFT (floor); registered with v2 and l2.
- Stage 3 (E2), only when v2 = 1:
  - not l2: acc <= acc + s (sign-extended to ACC_W; wraps modulo 2^ACC_W).
  - l2: r = (acc + s) >>> OUT_SHIFT; out_data <= sat_en ? clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1) : r[OUT_W-1:0]; out_valid <= 1; acc <= 0.
- When v2 = 0, out_valid <= 0 and out_data holds its value.
- sat_en is sampled at E2, not at beat entry.
- Beat counter: increments on each accepted in_valid and resets to 0 on an accepted in_last. A beat accepted while count = MAX_BEATS sets err. err clears only on clear or reset.
- Done counter: loads DONE_LEN on the edge after out_valid is high, decrements to 0; wb_done = (count != 0). A new out_valid reloads the counter, so back-to-back pulses merge.
- busy = v1 | v2 | (beat count != 0) | (acc != 0 not required; pass-open flag set by a non-last beat, cleared at E2 of the last beat).
- clear has priority over in_valid:
  - zeroes v1, v2, acc, beat count, pass-open, err, done counter and out_valid; the beat presented that cycle is dropped.
  - out_data holds its value.
- Reset (asynchronous, any time, including mid-pass): all registers go to 0. Outputs reset to out_valid = 0, out_data = 0, wb_done = 0, busy = 0, err = 0.

## Timing
- Fully pipelined, one beat per cycle, no backpressure; in_valid may be high every cycle and passes may be back to back.
- Latency: last beat sampled at E0 gives out_valid high during the cycle after E2 (3-cycle latency).
- wb_done is high from E3 through E3+DONE_LEN-1.
- A last beat with no preceding beats is a valid one-beat pass.
- Beat k+1 of the next pass may enter at E1 of the previous last beat; the accumulator restart is seamless.

## Test plan
- Single-beat pass, defaults: all ifmap = 64, weight = 64, in_last = 1 → sum 20480 >>> 7 = 160, >>> 2 = 40; out_data = 40, out_valid for 1 cycle, 3 cycles after sampling; wb_done high 3 cycles starting 1 cycle later.
- Three-beat pass with the same vectors, back to back → out_valid once after the third beat, out_data = 120; busy high from the first beat until out_valid; a one-beat pass issued next cycle gives 40 one cycle after.
- Four beats of ifmap = weight = 127, i.e. 80645 >>> 7 = 630 per beat, acc 2520 → r = 630; sat_en = 1 → 511; repeat with sat_en = 0 → -394.
- Tap 0 with ifmap = -1, weight = 1, others 0, single beat → out_data = -1 (floor shift); ifmap = -128, weight = -128 on all taps → 81920 >>> 7 = 640 >>> 2 = 160.
- Assert clear after 2 beats of a pass, then a fresh one-beat pass of 64s → 40, not 120; assert rst low mid-pass → all outputs 0 immediately; after release, the next pass is correct.
- MAX_BEATS = 4: 5 beats without last → err = 1 and stays set after a later last; out_valid pulses spaced 2 cycles apart → wb_done stays high continuously until DONE_LEN cycles after the final out_valid.
